stream_accum_top: RTL
=====================

# stream_accum_top

Parametrised streaming accumulator top for the FPGA accelerator path. It takes one AXI-Stream input of DATA_W-bit words and produces one AXI-Stream output after a selectable operation: pass-through, running sum, or per-frame sum. Results go through a DEPTH-entry output FIFO. It sits where the single-width HLS top sits today, between the DMA input stream and the DMA output stream, and adds width, framing, mode and buffering control.

## Interface
Parameters:
- DATA_W, 32: stream word width (8..64).
- FRAME_LEN, 4: words per frame (>=1).
- DEPTH, 4: output FIFO entries (power of 2, >=2).

Ports:
- aclk  in  1  single clock; all logic rises on this edge.
- aresetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- mode  in  2  0=pass, 1=running sum, 2=frame sum, 3=pass.
- input_V_V_TVALID  in  1  input word valid.
- input_V_V_TREADY  out  1  block can accept a word.
- input_V_V_TDATA  in  DATA_W  input word.
- output_V_V_TVALID  out  1  output word valid.
- output_V_V_TREADY  in  1  sink accepts the word.
- output_V_V_TDATA  out  DATA_W  output word (FIFO head).
- frame_count  out  16  number of completed input frames; wraps at 2^16.

## Operation
- Accept occurs when input_V_V_TVALID and input_V_V_TREADY are both high at a rising edge. Pop occurs when output_V_V_TVALID and output_V_V_TREADY are both high at a rising edge.
- Internal state:
  - acc (DATA_W bits).
  - idx, the word index within the frame, 0..FRAME_LEN-1.
  - cur_mode, 2 bits.
  - FIFO memory, read pointer, write pointer, and count (0..DEPTH).
- Mode latch: on an accept with idx==0, cur_mode takes mode, and the word is processed with the new mode. A change to mode mid-frame has no effect until the next frame starts.
- Processing on each accept, with s = acc + TDATA modulo 2^DATA_W (carry discarded):
  - pass (0 or 3): push TDATA. acc is unchanged.
  - running (1): push s. acc takes s, or 0 if this is the last word of the frame.
  - frame (2): no push unless this is the last word of the frame; then push s. acc takes s, or 0 on the last word.
- Frame end: when idx==FRAME_LEN-1, idx wraps to 0 and frame_count increments, in every mode. Otherwise idx increments.
- FIFO:
  - Push and pop in the same cycle are both allowed; count is then unchanged.
  - output_V_V_TVALID = (count != 0).
  - output_V_V_TDATA = mem[rd_ptr]. Its value is don't-care while TVALID is low.
  - Data and valid are held stable until popped (AXI-Stream rule).
- Ready: input_V_V_TREADY is a register whose next value is (count_next < DEPTH). It is conservative in frame mode: the block stalls when the FIFO is full even if the word would not push.
- Reset (aresetn low, asynchronous):
  - acc=0, idx=0, cur_mode=0, pointers and count=0, frame_count=0.
  - input_V_V_TREADY=0 and output_V_V_TVALID=0.
  - FIFO contents are not cleared.
- Reset mid-frame or mid-burst: all partial sums and queued words are discarded. After reset, the first accepted word starts a new frame.

## Timing
- TREADY rises on the first rising edge after aresetn deasserts.
- Latency: a word accepted at edge k (FIFO empty) gives TVALID high with the result from edge k onward, i.e. visible in cycle k+1. In frame mode this applies to the last word of the frame.
- Throughput is 1 word/cycle sustained in pass and running modes while the sink holds TREADY high.
- Full: when count reaches DEPTH at edge k, TREADY is low from edge k. After a pop at edge m, TREADY is high from edge m. There is no combinational ready path from output to input.
- Empty: TVALID falls at the edge of the last pop unless a push occurs at that same edge.
- acc and idx advance only on accepts. Stalled cycles leave all state unchanged.

## Test plan
DATA_W=32, FRAME_LEN=4, DEPTH=4 unless noted.
- Pass mode: send 1,2,3 back-to-back with sink ready -> output 1,2,3; each TVALID appears one cycle after its accept; frame_count=0.
- Running mode: send 1,2,3,4,5 -> output 1,3,6,10,5; frame_count=1.
- Frame mode: send 1..8 -> exactly two outputs, 10 and 26; frame_count=2. Wrap check in running mode: send 0xFFFFFFFF then 2 -> output 0xFFFFFFFF then 0x00000001.
- Backpressure: sink TREADY=0, send 6 words in pass mode -> 4 accepted, then input TREADY=0. Release the sink -> all 6 words delivered in order, no loss or duplication.
- Mode switch mid-frame: start in running mode with 1,2; set mode=2; send 3,4,5,6,7,8 -> outputs 1,3,6,10, then 26 (frame sum of 5..8).
- Reset mid-frame: running mode, send 5,5; pulse aresetn low for 1 cycle; send 1 -> output 1. TVALID and TREADY are 0 during reset, and frame_count=0 after it.

Source files
------------

// File: rtl/stream_accum_if.sv
// Stream port bundle for stream_accum_top: one AXI-Stream input and one
// AXI-Stream output.
//
// Handshake: a word moves on a rising edge where TVALID and TREADY are both
// high. A source that raised TVALID keeps TVALID and TDATA stable until that
// transfer happens. A sink may change TREADY at any time.
interface stream_accum_if #(
  parameter int DATA_W = 32
);
  logic              input_V_V_TVALID;
  logic              input_V_V_TREADY;
  logic [DATA_W-1:0] input_V_V_TDATA;
  logic              output_V_V_TVALID;
  logic              output_V_V_TREADY;
  logic [DATA_W-1:0] output_V_V_TDATA;

  // Accumulator side: consumes the input stream and sources the output stream
  modport slave (
    input  input_V_V_TVALID,
    input  input_V_V_TDATA,
    output input_V_V_TREADY,
    output output_V_V_TVALID,
    output output_V_V_TDATA,
    input  output_V_V_TREADY
  );

  // Environment side: sources the input stream and consumes the output stream
  modport master (
    output input_V_V_TVALID,
    output input_V_V_TDATA,
    input  input_V_V_TREADY,
    input  output_V_V_TVALID,
    input  output_V_V_TDATA,
    output output_V_V_TREADY
  );
endinterface

// File: rtl/stream_accum_top.sv
// Streaming accumulator: pass-through, running sum or per-frame sum of the
// input words, with results queued in a DEPTH-entry output FIFO.
// The mode is sampled at the first word of each frame. Input ready is
// registered, so there is no combinational path from output to input.
module stream_accum_top #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 4,
  parameter int DEPTH     = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [1:0]      mode,
  stream_accum_if.slave   axis,
  output logic [15:0]     frame_count
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_FRAME = 2'd2,
    MODE_PASS3 = 2'd3
  } mode_e;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  mode_e             cur_mode_q, cur_mode_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              pop;
  logic              push;
  logic              last;
  mode_e             eff_mode;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] push_data;

  // Accept/process one word, advance frame position and FIFO bookkeeping
  always_comb begin
    accept        = axis.input_V_V_TVALID && in_ready_q;
    pop           = (count_q != '0) && axis.output_V_V_TREADY;
    eff_mode      = (idx_q == '0) ? mode_e'(mode) : cur_mode_q;
    last          = (idx_q == IDX_LAST);
    sum           = acc_q + axis.input_V_V_TDATA;
    acc_d         = acc_q;
    idx_d         = idx_q;
    cur_mode_d    = cur_mode_q;
    frame_count_d = frame_count_q;
    push          = 1'b0;
    push_data     = axis.input_V_V_TDATA;
    if (accept) begin
      cur_mode_d = eff_mode;
      case (eff_mode)
        MODE_RUN: begin
          push      = 1'b1;
          push_data = sum;
          acc_d     = last ? '0 : sum;
        end
        MODE_FRAME: begin
          push      = last;
          push_data = sum;
          acc_d     = last ? '0 : sum;
        end
        default: begin
          push      = 1'b1;
          push_data = axis.input_V_V_TDATA;
        end
      endcase
      if (last) begin
        idx_d         = '0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    in_ready_d = (count_d < CNT_FULL);
  end

  // Control state register, cleared asynchronously
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q         <= '0;
      idx_q         <= '0;
      cur_mode_q    <= MODE_PASS;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_count_q <= '0;
      in_ready_q    <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      cur_mode_q    <= cur_mode_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
      in_ready_q    <= in_ready_d;
    end
  end

  // FIFO storage write; contents survive reset, only pointers are cleared
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign axis.input_V_V_TREADY  = in_ready_q;
  assign axis.output_V_V_TVALID = (count_q != '0);
  assign axis.output_V_V_TDATA  = mem_q[rd_ptr_q];
  assign frame_count            = frame_count_q;

endmodule
